// File: rtl/ucdp_latch_wrarb.sv
// ucdp_latch_wrarb: round-robin write arbiter for a latch-based register bank.
// Registered d_o/ld_o keep each latch word transparent only in the low clock phase.
module ucdp_latch_wrarb #(
  parameter int width_p = 8,
  parameter int depth_p = 4,
  parameter int reqs_p  = 2
) (
  input  logic                         main_clk_i,
  input  logic                         main_rst_an_i,
  input  logic                         en_i,
  input  logic [reqs_p-1:0]            req_i,
  input  logic [reqs_p*$clog2(depth_p)-1:0] addr_i,
  input  logic [reqs_p*width_p-1:0]    data_i,
  output logic [reqs_p-1:0]            gnt_o,
  output logic [depth_p-1:0]           ld_o,
  output logic [width_p-1:0]           d_o,
  output logic                         err_o,
  output logic                         busy_o
);

  localparam int awidth_p = $clog2(depth_p);
  localparam int pw_p     = (reqs_p > 1) ? $clog2(reqs_p) : 1;

  logic [pw_p-1:0]     ptr_q, ptr_d;
  logic [pw_p-1:0]     sel;
  logic                vld;
  logic [awidth_p-1:0] a_sel;
  logic [width_p-1:0]  w_sel;
  logic [depth_p-1:0]  ld_q, ld_d;
  logic [width_p-1:0]  d_q, d_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  int                  k;

  // Search from ptr upward, wrapping at reqs_p.
  always_comb begin
    sel   = ptr_q;
    vld   = 1'b0;
    k     = 0;
    gnt_o = '0;
    if (en_i && main_rst_an_i) begin
      for (int i = 0; i < reqs_p; i++) begin
        k = int'(ptr_q) + i;
        if (k >= reqs_p) k = k - reqs_p;
        if (!vld && req_i[k]) begin
          vld = 1'b1;
          sel = pw_p'(k);
        end
      end
    end
    if (vld) gnt_o[sel] = 1'b1;
  end

  assign a_sel = addr_i[sel*awidth_p +: awidth_p];
  assign w_sel = data_i[sel*width_p +: width_p];

  always_comb begin
    ptr_d  = ptr_q;
    ld_d   = '0;
    err_d  = 1'b0;
    busy_d = vld;
    d_d    = d_q;
    if (vld) begin
      ptr_d = (sel == pw_p'(reqs_p-1)) ? '0 : sel + 1'b1;
      d_d   = w_sel;
      if (int'(a_sel) < depth_p) ld_d[a_sel] = 1'b1;
      else                       err_d       = 1'b1;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      ptr_q  <= '0;
      ld_q   <= '0;
      d_q    <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      ld_q   <= ld_d;
      d_q    <= d_d;
      err_q  <= err_d;
      busy_q <= busy_d;
    end
  end

  assign ld_o   = ld_q;
  assign d_o    = d_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_ucdp_latch_wrarb.sv
// Directed bench for ucdp_latch_wrarb: depth 4 and depth 3 instances,
// with a behavioural latch bank loading in the low phase.
module tb_ucdp_latch_wrarb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [1:0] req;
  logic [3:0] addr;
  logic [15:0] data;
  logic [1:0] gnt;
  logic [3:0] ld;
  logic [7:0] d;
  logic       err, busy;

  logic [1:0] req3;
  logic [3:0] addr3;
  logic [15:0] data3;
  logic [1:0] gnt3;
  logic [2:0] ld3;
  logic [7:0] d3;
  logic       err3, busy3;

  logic [7:0] word [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ucdp_latch_wrarb #(.width_p(8), .depth_p(4), .reqs_p(2)) u_dut (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .en_i(en),
    .req_i(req), .addr_i(addr), .data_i(data),
    .gnt_o(gnt), .ld_o(ld), .d_o(d), .err_o(err), .busy_o(busy)
  );

  ucdp_latch_wrarb #(.width_p(8), .depth_p(3), .reqs_p(2)) u_dut3 (
    .main_clk_i(clk), .main_rst_an_i(rst_n), .en_i(en),
    .req_i(req3), .addr_i(addr3), .data_i(data3),
    .gnt_o(gnt3), .ld_o(ld3), .d_o(d3), .err_o(err3), .busy_o(busy3)
  );

  always @(negedge clk) begin
    if (rst_n)
      for (int i = 0; i < 4; i++)
        if (ld[i]) word[i] <= d;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] g_exp [4];
  logic [1:0] b_a [3];
  logic [7:0] b_d [3];
  logic [3:0] b_ld [3];

  initial begin
    g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    b_a   = '{2'd0, 2'd0, 2'd3};
    b_d   = '{8'h11, 8'h22, 8'h33};
    b_ld  = '{4'b0001, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) word[i] = 8'h00;

    rst_n = 1'b0; en = 1'b1; req = 2'b01; addr = '0; data = '0;
    req3 = '0; addr3 = '0; data3 = '0;
    #3;
    check("rst_gnt", gnt, 2'b00);
    check("rst_ld", ld, 4'b0000);
    check("rst_d", d, 8'h00);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    cyc();
    rst_n = 1'b1; req = 2'b00;

    // single write
    cyc();
    req = 2'b01; addr = {2'd0, 2'd2}; data = {8'h00, 8'hA5};
    #1 check("w1_gnt", gnt, 2'b01);
    cyc();
    req = 2'b00;
    check("w1_ld", ld, 4'b0100);
    check("w1_d", d, 8'hA5);
    check("w1_busy", busy, 1'b1);
    check("w1_err", err, 1'b0);
    cyc();
    check("w1_ld_clr", ld, 4'b0000);
    check("w1_busy_clr", busy, 1'b0);
    check("w1_d_hold", d, 8'hA5);
    check("w1_word2", word[2], 8'hA5);

    // requester 1 write, returns ptr to 0
    req = 2'b10; addr = {2'd1, 2'd0}; data = {8'h5A, 8'h00};
    #1 check("w2_gnt", gnt, 2'b10);
    cyc();
    req = 2'b00;
    check("w2_ld", ld, 4'b0010);
    check("w2_d", d, 8'h5A);

    // contention
    req = 2'b11; addr = {2'd3, 2'd0}; data = {8'h20, 8'h10};
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_gnt", gnt, g_exp[i]);
      if (i > 0) begin
        check("rr_ld", ld, (g_exp[i-1] == 2'b01) ? 4'b0001 : 4'b1000);
        check("rr_d", d, (g_exp[i-1] == 2'b01) ? 8'h10 : 8'h20);
      end
      cyc();
    end
    req = 2'b00;
    check("rr_ld_last", ld, 4'b1000);
    check("rr_d_last", d, 8'h20);

    // enable
    req = 2'b01; addr = {2'd3, 2'd1}; data = {8'h20, 8'h77};
    #1 check("en_gnt", gnt, 2'b01);
    cyc();
    en = 1'b0; req = 2'b11;
    #1 check("en0_gnt", gnt, 2'b00);
    check("en0_ld_done", ld, 4'b0010);
    check("en0_d_done", d, 8'h77);
    cyc();
    check("en0_ld", ld, 4'b0000);
    check("en0_busy", busy, 1'b0);
    en = 1'b1;
    #1 check("en1_gnt", gnt, 2'b10);
    cyc();
    req = 2'b00;
    check("en1_ld", ld, 4'b1000);
    check("en1_d", d, 8'h20);

    // back-to-back
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      addr[1:0] = b_a[i];
      data[7:0] = b_d[i];
      #1 check("b2b_gnt", gnt, 2'b01);
      cyc();
      check("b2b_ld", ld, b_ld[i]);
      check("b2b_d", d, b_d[i]);
    end
    req = 2'b00;
    cyc();
    check("b2b_ld_clr", ld, 4'b0000);
    check("b2b_word0", word[0], 8'h22);
    check("b2b_word3", word[3], 8'h33);
    check("b2b_word2", word[2], 8'hA5);

    // bad address on depth 3
    req3 = 2'b01; addr3 = {2'd0, 2'd3}; data3 = {8'h00, 8'h99};
    #1 check("bad_gnt", gnt3, 2'b01);
    cyc();
    req3 = 2'b00;
    check("bad_err", err3, 1'b1);
    check("bad_ld", ld3, 3'b000);
    check("bad_busy", busy3, 1'b1);
    check("bad_d", d3, 8'h99);
    cyc();
    check("bad_err_clr", err3, 1'b0);
    check("bad_busy_clr", busy3, 1'b0);
    req3 = 2'b10; addr3 = {2'd2, 2'd3}; data3 = {8'h44, 8'h99};
    #1 check("ok3_gnt", gnt3, 2'b10);
    cyc();
    req3 = 2'b00;
    check("ok3_ld", ld3, 3'b100);
    check("ok3_err", err3, 1'b0);
    check("ok3_d", d3, 8'h44);

    // reset mid-write
    req = 2'b01; addr = {2'd0, 2'd1}; data = {8'h00, 8'hC3};
    cyc();
    req = 2'b00;
    check("mr_ld", ld, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("mr_ld0", ld, 4'b0000);
    check("mr_d0", d, 8'h00);
    check("mr_err0", err, 1'b0);
    check("mr_busy0", busy, 1'b0);
    cyc();
    rst_n = 1'b1; req = 2'b11;
    #1 check("mr_ptr0", gnt, 2'b01);
    req = 2'b00;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
